// File: rtl/hier_leaf_stream_fifo.sv
// hier_leaf_stream_fifo
//   Leaf-level valid/ready stream buffer used beneath each fan-out node of the
//   generated hierarchy. It is a first-word fall-through FIFO with registered
//   occupancy and fill-level status decoded from that occupancy.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   flush      synchronous clear of pointers/occupancy (contents are kept)
//   in_valid   upstream word present
//   in_ready   FIFO can accept a word (= !full)
//   in_data    upstream payload
//   out_valid  head word present (= !empty)
//   out_ready  downstream accepts head word
//   out_data   head payload, read combinationally from the storage array
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   hwm        count >= HWM
//
// Optional feature (macro HIER_LEAF_PARITY_EN):
//   in_par     expected even parity of in_data
//   par_err    sticky error flag, set after an accepted push with bad parity,
//              cleared only by rst or flush
module hier_leaf_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int HWM    = 3,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef HIER_LEAF_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              hwm
);

  localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] HWM_LVL  = HWM[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic              push;
  logic              pop;

  // Status comes straight from the registered count, so no extra latency.
  assign full      = (count == FULL_LVL);
  assign empty     = (count == '0);
  assign hwm       = (count >= HWM_LVL);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rp];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push = in_valid && !full;
  assign pop  = out_ready && !empty;

  // Storage is not cleared by reset or flush; only pointers and count are.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wp] <= in_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef HIER_LEAF_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      par_err <= 1'b0;
    end else if (push && ((^in_data) ^ in_par)) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hier_leaf_stream_fifo.sv
module tb_hier_leaf_stream_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int HWM   = 3;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic          full, empty, hwm;
  logic [DW-1:0] in_data, out_data;
  logic [AW:0]   count;
`ifdef HIER_LEAF_PARITY_EN
  logic          in_par, par_err;
  bit            m_perr;
`endif

  hier_leaf_stream_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .HWM(HWM)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef HIER_LEAF_PARITY_EN
    .in_par(in_par), .par_err(par_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .hwm(hwm)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] q[$];

  typedef struct {
    bit            r, f, iv;
    logic [DW-1:0] d;
    bit            ordy;
    int            cnt;
    bit            ov;
    logic [DW-1:0] od;
    bit            fl, em, hw, ir;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("hwm", hwm, q.size() >= HWM);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) chk("out_data", out_data, q[0]);
`ifdef HIER_LEAF_PARITY_EN
    chk("par_err", par_err, m_perr);
`endif
  endtask

  // One clock: the queue model applies the rules to the inputs present
  // before the edge, then DUT outputs are compared #1 after the edge.
  task automatic cycle();
    bit mpush, mpop;
    mpush = in_valid && (q.size() < DEPTH);
    mpop  = out_ready && (q.size() > 0);
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
`ifdef HIER_LEAF_PARITY_EN
      m_perr = 1'b0;
`endif
    end else begin
      if (mpop) void'(q.pop_front());
      if (mpush) begin
        q.push_back(in_data);
`ifdef HIER_LEAF_PARITY_EN
        if ((^in_data) != in_par) m_perr = 1'b1;
`endif
      end
    end
    #1;
    check_model();
  endtask

  task automatic drive(input bit r, input bit f, input bit iv, input logic [DW-1:0] d, input bit o);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
`ifdef HIER_LEAF_PARITY_EN
    in_par = ^d;
`endif
  endtask

  initial begin
    int            exp_next;
    int            word;
    int            budget;
    logic [DW-1:0] w;

    drive(1, 0, 0, 8'h00, 0);

    //          r f iv d      or cnt ov od     fl em hw ir
    tbl[0]  = '{1,0,0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 1};
    tbl[1]  = '{1,0,0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 1};
    tbl[2]  = '{0,0,1, 8'h11, 0, 1, 1, 8'h11, 0, 0, 0, 1};
    tbl[3]  = '{0,0,1, 8'h22, 0, 2, 1, 8'h11, 0, 0, 0, 1};
    tbl[4]  = '{0,0,1, 8'h33, 0, 3, 1, 8'h11, 0, 0, 1, 1};
    tbl[5]  = '{0,0,1, 8'h44, 0, 4, 1, 8'h11, 1, 0, 1, 0};
    tbl[6]  = '{0,0,1, 8'h55, 0, 4, 1, 8'h11, 1, 0, 1, 0};
    tbl[7]  = '{0,0,1, 8'h55, 1, 3, 1, 8'h22, 0, 0, 1, 1};
    tbl[8]  = '{0,0,0, 8'h00, 1, 2, 1, 8'h33, 0, 0, 0, 1};
    tbl[9]  = '{0,0,0, 8'h00, 1, 1, 1, 8'h44, 0, 0, 0, 1};
    tbl[10] = '{0,0,0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, 1};
    tbl[11] = '{0,0,0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, 1};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      cycle();
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].fl);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].em);
      chk($sformatf("tbl%0d_hwm", i), hwm, tbl[i].hw);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
      if (tbl[i].ov) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].od);
    end

    // Streaming: two words preloaded, then push+pop every cycle.
    drive(1, 0, 0, 8'h00, 0); cycle();
    drive(0, 0, 1, 8'hA0, 0); cycle();
    drive(0, 0, 1, 8'hA1, 0); cycle();
    for (int k = 0; k < 10; k++) begin
      w = 8'hA2 + 8'(k);
      drive(0, 0, 1, w, 1);
      chk("stream_head", out_data, 8'hA0 + 8'(k));
      cycle();
      chk("stream_count", count, 2);
    end

    // Wrap: 9 words with random out_ready, order checked across pointer wrap.
    drive(1, 0, 0, 8'h00, 0); cycle();
    word = 1; exp_next = 1; budget = 0;
    while (exp_next <= 9 && budget < 200) begin
      drive(0, 0, word <= 9, 8'(word), 1'($urandom_range(0, 1)));
      if (out_ready && q.size() > 0) begin
        chk("wrap_order", out_data, exp_next);
        exp_next++;
      end
      if (in_valid && q.size() < DEPTH) word++;
      cycle();
      chk("wrap_bound", count <= 4, 1);
      budget++;
    end
    chk("wrap_done", exp_next, 10);

    // Flush at count=3 together with a push of 0xAA.
    drive(1, 0, 0, 8'h00, 0); cycle();
    drive(0, 0, 1, 8'hB1, 0); cycle();
    drive(0, 0, 1, 8'hB2, 0); cycle();
    drive(0, 0, 1, 8'hB3, 0); cycle();
    chk("flush_pre_count", count, 3);
    drive(0, 1, 1, 8'hAA, 1); cycle();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 8'h00, 1); cycle();
      chk("flush_no_out", out_valid, 0);
    end
    drive(0, 0, 1, 8'h5C, 0); cycle();
    chk("flush_after_data", out_data, 8'h5C);
    drive(0, 0, 0, 8'h00, 1); cycle();
    chk("flush_after_empty", empty, 1);

`ifdef HIER_LEAF_PARITY_EN
    drive(1, 0, 0, 8'h00, 0); cycle();
    drive(0, 0, 1, 8'h03, 0); in_par = 1'b1; cycle();
    chk("par_set", par_err, 1);
    drive(0, 0, 1, 8'h05, 0); cycle();
    chk("par_sticky", par_err, 1);
    drive(0, 0, 1, 8'h07, 1); cycle();
    chk("par_sticky2", par_err, 1);
    drive(0, 1, 0, 8'h00, 0); cycle();
    chk("par_clear", par_err, 0);
`endif

    // Randomized traffic with occasional flush and reset against the queue model.
    drive(1, 0, 0, 8'h00, 0); cycle();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)));
`ifdef HIER_LEAF_PARITY_EN
      in_par = ($urandom_range(0, 15) == 0) ? ~(^in_data) : ^in_data;
`endif
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
